// File: rtl/pipe_ctl_pkg.sv
// Shared types for the pipe controller: FSM states, opcode constants and routing classes.
package pipe_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM,
    WB
  } state_e;

  typedef enum logic [1:0] {
    BR,
    LS,
    ALU,
    ILL
  } route_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Timer slots, one per latency domain; index order matches the packed latency vector.
  localparam int NUM_TIMERS = 5;
  localparam int T_FETCH    = 0;
  localparam int T_DEC      = 1;
  localparam int T_GPR      = 2;
  localparam int T_MEM      = 3;
  localparam int T_WB       = 4;

  function automatic route_e route_of(input logic [6:0] op);
    route_e rc;
    case (op)
      OP_BRANCH, OP_JAL, OP_JALR:         rc = BR;
      OP_LOAD, OP_STORE:                  rc = LS;
      OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC:  rc = ALU;
      default:                            rc = ILL;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/sync_pipe_controller_stage_timer.sv
// Loadable 8-bit down-counter; done is high while the count sits at zero.
module stage_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != 8'd0) begin
      count_reg <= count_reg - 8'd1;
    end
  end

  assign done = (count_reg == 8'd0);

endmodule

// File: rtl/sync_pipe_controller.sv
// Single-issue multi-cycle pipe sequencer with fork/join decode and opcode routing.
// Optional macro PIPE_CTL_PERF_EN adds the retire_cnt performance counter port.
module sync_pipe_controller
  import pipe_ctl_pkg::*;
#(
  parameter int unsigned FETCH_LAT = 1,
  parameter int unsigned DEC_LAT   = 2,
  parameter int unsigned GPR_LAT   = 1,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned WB_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        mem_ack,
  output logic        req1,
  output logic        req2_1,
  output logic        req2_2,
  output logic        req3,
  output logic        req4,
  output logic        busy,
  output logic        retire,
  output logic        illegal
`ifdef PIPE_CTL_PERF_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  localparam logic [8*NUM_TIMERS-1:0] LAT_VEC = {
    8'(WB_LAT - 1), 8'(MEM_LAT - 1), 8'(GPR_LAT - 1), 8'(DEC_LAT - 1), 8'(FETCH_LAT - 1)
  };

  state_e                  state_reg, state_next;
  logic                    armed_reg;
  logic [6:0]              opcode_reg;
  logic                    opcode_latch;
  logic [NUM_TIMERS-1:0]   timer_load;
  logic [NUM_TIMERS-1:0]   timer_done;
  logic                    req1_reg, req2_1_reg, req2_2_reg, req3_reg, req4_reg;
  logic                    retire_next, illegal_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TIMERS; gi++) begin : g_timer
      stage_timer u_timer (
        .clk      (clk),
        .rst      (reset),
        .load     (timer_load[gi]),
        .load_val (LAT_VEC[gi*8 +: 8]),
        .done     (timer_done[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    retire_next  = 1'b0;
    illegal_next = 1'b0;
    opcode_latch = 1'b0;
    case (state_reg)
      IDLE: begin
        // The first edge after reset only arms the FSM.
        if (run && armed_reg) state_next = FETCH;
      end
      FETCH: begin
        if (timer_done[T_FETCH]) state_next = DECODE;
      end
      DECODE: begin
        if (timer_done[T_DEC] && timer_done[T_GPR]) begin
          opcode_latch = 1'b1;
          case (route_of(opcode))
            BR: begin
              retire_next = 1'b1;
              state_next  = run ? FETCH : IDLE;
            end
            LS:  state_next = MEM;
            ALU: state_next = WB;
            default: begin
              illegal_next = 1'b1;
              state_next   = run ? FETCH : IDLE;
            end
          endcase
        end
      end
      MEM: begin
        if (timer_done[T_MEM] && mem_ack) begin
          if (opcode_reg == OP_LOAD) begin
            state_next = WB;
          end else begin
            retire_next = 1'b1;
            state_next  = run ? FETCH : IDLE;
          end
        end
      end
      WB: begin
        if (timer_done[T_WB]) begin
          retire_next = 1'b1;
          state_next  = run ? FETCH : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    timer_load           = '0;
    timer_load[T_FETCH]  = (state_next == FETCH)  && (state_reg != FETCH);
    timer_load[T_DEC]    = (state_next == DECODE) && (state_reg != DECODE);
    timer_load[T_GPR]    = (state_next == DECODE) && (state_reg != DECODE);
    timer_load[T_MEM]    = (state_next == MEM)    && (state_reg != MEM);
    timer_load[T_WB]     = (state_next == WB)     && (state_reg != WB);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      armed_reg  <= 1'b0;
      opcode_reg <= '0;
      req1_reg   <= 1'b0;
      req2_1_reg <= 1'b0;
      req2_2_reg <= 1'b0;
      req3_reg   <= 1'b0;
      req4_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      armed_reg  <= 1'b1;
      if (opcode_latch) opcode_reg <= opcode;
      req1_reg   <= (state_next == FETCH);
      // Each decode branch stays up from DECODE entry until its own timer expires.
      req2_1_reg <= (state_next == DECODE) &&
                    (timer_load[T_DEC] || (req2_1_reg && !timer_done[T_DEC]));
      req2_2_reg <= (state_next == DECODE) &&
                    (timer_load[T_GPR] || (req2_2_reg && !timer_done[T_GPR]));
      req3_reg   <= (state_next == MEM);
      req4_reg   <= (state_next == WB);
    end
  end

`ifdef PIPE_CTL_PERF_EN
  logic [31:0] retire_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt_reg <= '0;
    end else if (retire_next) begin
      retire_cnt_reg <= retire_cnt_reg + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_reg;
`endif

  assign req1    = req1_reg;
  assign req2_1  = req2_1_reg;
  assign req2_2  = req2_2_reg;
  assign req3    = req3_reg;
  assign req4    = req4_reg;
  assign busy    = (state_reg != IDLE);
  assign retire  = retire_next;
  assign illegal = illegal_next;

endmodule

// File: doc/sync_pipe_controller.md
SYNC_PIPE_CONTROLLER -- requirements
Module: sync_pipe_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameters SHALL be:
- FETCH_LAT, default 1, fetch stage cycles
- DEC_LAT, default 2, decode branch cycles
- GPR_LAT, default 1, register-read branch cycles
- MEM_LAT, default 2, minimum memory stage cycles
- WB_LAT, default 1, writeback cycles
- All latencies SHALL be 1..255.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  async active-high reset
- run  in  1  enable instruction issue
- opcode  in  7  RV32 opcode of the current instruction
- mem_ack  in  1  memory completion
- req1  out  1  fetch stage active
- req2_1  out  1  decode branch active
- req2_2  out  1  register-read branch active
- req3  out  1  memory stage active
- req4  out  1  writeback stage active
- busy  out  1  state is not IDLE
- retire  out  1  one-cycle pulse, instruction completed
- illegal  out  1  one-cycle pulse, unknown opcode

Function
REQ-004 The FSM SHALL have states IDLE, FETCH, DECODE, MEM and WB, with one instruction in flight.
REQ-005 IDLE SHALL go to FETCH on the next edge when run=1.
REQ-006 Each stage SHALL load its timer with LAT-1 on entry.
REQ-007 FETCH SHALL last exactly FETCH_LAT cycles and then go to DECODE.
REQ-008 DECODE SHALL raise req2_1 and req2_2 together (fork).
- Each SHALL drop after its own latency.
- The state SHALL exit when both are done (join), after max(DEC_LAT, GPR_LAT) cycles.
REQ-009 opcode SHALL be sampled and latched on the last DECODE cycle, then held for the rest of the instruction.
REQ-010 Routing on the latched opcode SHALL be:
- 1100011, 1101111, 1100111 (branch/jump): retire, then go to FETCH
- 0000011 (load) and 0100011 (store): go to MEM
- 0110011, 0010011, 0110111, 0010111 (ALU): go to WB
- any other opcode: pulse illegal, go to FETCH, no retire
REQ-011 MEM SHALL last at least MEM_LAT cycles.
- It SHALL exit on the first cycle where the timer is done and mem_ack=1.
- A load SHALL go to WB.
- A store SHALL retire and go to FETCH.
- mem_ack before the timer is done SHALL be ignored.
REQ-012 WB SHALL last exactly WB_LAT cycles, then retire.
REQ-013 retire SHALL be high only in the last cycle of the retiring stage.
REQ-014 After a retire or illegal, the next state SHALL be FETCH if run=1, else IDLE.
REQ-015 Deasserting run mid-instruction SHALL NOT abort the instruction.
REQ-016 Each reqN SHALL be a registered level, high exactly while its stage or branch is active, and never two stages at once except req2_1 with req2_2.

Reset
REQ-017 Reset SHALL force state IDLE and clear all outputs, timers and the opcode latch to 0 immediately, including mid-stage.
REQ-018 After reset release, the first FETCH SHALL start no earlier than the second edge with run=1.

Configuration
REQ-019 With PIPE_CTL_PERF_EN defined, the block SHALL add a 32-bit output retire_cnt.
- retire_cnt SHALL increment on retire, wrap at 2^32-1 to 0, and clear on reset.
- Without the macro the port and its counter SHALL be absent.

Structure
REQ-020 Package pipe_ctl_pkg SHALL hold the state enum, the opcode localparams and the route-class enum (BR, LS, ALU, ILL).
REQ-021 Sub-module stage_timer SHALL provide load, an 8-bit down-counter and a done flag, with one instance per latency domain.

Verification
REQ-022 Defaults, ALU 0110011, run=1 from cycle 0:
- req1 in cycle 1
- req2_1 in cycles 2-3, req2_2 in cycle 2
- req4 and retire in cycle 4
- req1 again in cycle 5
REQ-023 Load 0000011, mem_ack low until cycle 8:
- req3 in cycles 4-8
- req4 and retire in cycle 9
REQ-024 Store 0100011, mem_ack=1:
- req3 in cycles 4-5, retire in cycle 5
- req4 never asserts
REQ-025 Branch 1100011: retire in cycle 3, with no req3 and no req4.
REQ-026 Opcode 0000000:
- illegal in cycle 3, no retire
- run=0 at that time leads to IDLE in cycle 4 with busy=0
REQ-027 Reset pulse in cycle 5 of a load: all outputs 0 within that cycle, and with PERF retire_cnt=0 afterwards.
